// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared widths, M-op codes and FSM states for the iterative mul/div unit
package ex_muldiv_pkg;
    localparam int XLEN = 32;
    localparam int CNT_W = 6;
    localparam int MD_STEPS = 32;
    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } md_op_e;
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;
endpackage

// File: rtl/ex_muldiv_datapath.sv
// ex_muldiv_datapath: one shift-add / restoring shift-subtract step plus result sign fix-up
module ex_muldiv_datapath
    import ex_muldiv_pkg::*;
(
    input  logic                is_div,
    input  logic [2:0]          op,
    input  logic                neg,
    input  logic [2*XLEN-1:0]   p,
    input  logic [XLEN-1:0]     d,
    output logic [2*XLEN-1:0]   p_next,
    output logic [XLEN-1:0]     res
);
    logic [XLEN:0] sum, rem_sh, diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] sel;
    // p holds {acc, multiplier} for MUL and {remainder, quotient} for DIV; res is taken from the post-step value
    always_comb begin
        sum = {1'b0, p[63:32]} + (p[0] ? {1'b0, d} : 33'd0);
        rem_sh = p[63:31];
        diff = rem_sh - {1'b0, d};
        p_next = is_div ? (diff[32] ? {rem_sh[31:0], p[30:0], 1'b0} : {diff[31:0], p[30:0], 1'b1})
                        : {sum, p[31:1]};
        prod = neg ? -p_next : p_next;
        sel = op[1] ? p_next[63:32] : p_next[31:0];
        res = op[2] ? (neg ? -sel : sel) : (op == MD_MUL ? prod[31:0] : prod[63:32]);
    end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit with pipeline stall handshake
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        opValid_in,
    input  logic [2:0]  op_in,
    input  logic [31:0] rs1Data_in,
    input  logic [31:0] rs2Data_in,
    input  logic [4:0]  rdIdx_in,
    input  logic        accept_in,
    output logic        stallReq_out,
    output logic        done_out,
    output logic [31:0] result_out,
    output logic        rdE_out,
    output logic [4:0]  rdIdx_out
);
    state_e state;
    logic [2:0] op;
    logic neg, neg_in, sa, sb, zero, ovf;
    logic [XLEN-1:0] opnd, ma, mb, special, res;
    logic [2*XLEN-1:0] p, p_next;
    logic [CNT_W-1:0] cnt;

    ex_muldiv_datapath u_dp (
        .is_div (state == ST_DIV),
        .op     (op),
        .neg    (neg),
        .p      (p),
        .d      (opnd),
        .p_next (p_next),
        .res    (res)
    );

    assign stallReq_out = (state == ST_IDLE && opValid_in) || state == ST_MUL || state == ST_DIV;

    // accept-time decode: operand signedness, magnitudes, and the divide-by-zero / overflow shortcuts
    always_comb begin
        sa = rs1Data_in[31] && (op_in[2] ? !op_in[0] : op_in[0] ^ op_in[1]);
        sb = rs2Data_in[31] && (op_in[2] ? !op_in[0] : op_in == MD_MULH);
        ma = sa ? -rs1Data_in : rs1Data_in;
        mb = sb ? -rs2Data_in : rs2Data_in;
        neg_in = (op_in[2] && op_in[1]) ? sa : sa ^ sb;
        zero = op_in[2] && rs2Data_in == '0;
        ovf = op_in[2] && !op_in[0] && rs1Data_in == 32'h8000_0000 && rs2Data_in == '1;
        special = zero ? (op_in[1] ? rs1Data_in : '1) : (op_in[1] ? '0 : 32'h8000_0000);
    end

    // control FSM and registered result handshake; a frozen cycle (rdy_in=0) holds everything
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= ST_IDLE;
            cnt <= '0;
            op <= '0;
            neg <= 1'b0;
            opnd <= '0;
            p <= '0;
            done_out <= 1'b0;
            rdE_out <= 1'b0;
            result_out <= '0;
            rdIdx_out <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                state <= ST_IDLE;
                cnt <= '0;
                done_out <= 1'b0;
                rdE_out <= 1'b0;
                result_out <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (opValid_in) begin
                        op <= op_in;
                        neg <= neg_in;
                        opnd <= op_in[2] ? mb : ma;
                        p <= {32'd0, op_in[2] ? ma : mb};
                        cnt <= '0;
                        rdIdx_out <= rdIdx_in;
                        if (zero || ovf) begin
                            state <= ST_DONE;
                            result_out <= special;
                            done_out <= 1'b1;
                            rdE_out <= rdIdx_in != '0;
                        end else begin
                            state <= op_in[2] ? ST_DIV : ST_MUL;
                        end
                    end
                    ST_MUL, ST_DIV: begin
                        p <= p_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(MD_STEPS - 1)) begin
                            state <= ST_DONE;
                            result_out <= res;
                            done_out <= 1'b1;
                            rdE_out <= rdIdx_out != '0;
                        end
                    end
                    ST_DONE: if (accept_in) begin
                        state <= ST_IDLE;
                        done_out <= 1'b0;
                        rdE_out <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: table-driven vectors plus hold, flush, freeze and reset sequences
module tb_ex_muldiv;
    logic clk_in = 1'b0;
    logic rst_in, rdy_in, flush_in, opValid_in, accept_in;
    logic [2:0] op_in;
    logic [31:0] rs1Data_in, rs2Data_in;
    logic [4:0] rdIdx_in;
    logic stallReq_out, done_out, rdE_out;
    logic [31:0] result_out;
    logic [4:0] rdIdx_out;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    ex_muldiv dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush_in     (flush_in),
        .opValid_in   (opValid_in),
        .op_in        (op_in),
        .rs1Data_in   (rs1Data_in),
        .rs2Data_in   (rs2Data_in),
        .rdIdx_in     (rdIdx_in),
        .accept_in    (accept_in),
        .stallReq_out (stallReq_out),
        .done_out     (done_out),
        .result_out   (result_out),
        .rdE_out      (rdE_out),
        .rdIdx_out    (rdIdx_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic acc, input string name);
        opValid_in = 1'b1;
        op_in = op;
        rs1Data_in = a;
        rs2Data_in = b;
        rdIdx_in = rd;
        accept_in = acc;
        #1;
        chk({name, "_stall_issue"}, 32'(stallReq_out), 32'd1);
        @(negedge clk_in);
    endtask

    task automatic wait_done(output int lat, output bit stall_ok);
        lat = 1;
        stall_ok = 1'b1;
        while (!done_out && lat < 100) begin
            stall_ok &= stallReq_out;
            @(negedge clk_in);
            lat++;
        end
        stall_ok &= !stallReq_out;
    endtask

    initial begin
        int lat;
        bit sok;
        vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 33});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 33});
        vecs.push_back('{3'd3, 32'h8000_0000, 32'd2,         5'd5,  32'h0000_0001, 33});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, 33});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, 33});
        vecs.push_back('{3'd5, 32'd100,        32'd7,         5'd8,  32'd14,        33});
        vecs.push_back('{3'd7, 32'd100,        32'd7,         5'd9,  32'd2,         33});
        vecs.push_back('{3'd4, 32'd20,         32'hFFFF_FFFA, 5'd10, 32'hFFFF_FFFD, 33});
        vecs.push_back('{3'd6, 32'd20,         32'hFFFF_FFFA, 5'd0,  32'd2,         33});
        vecs.push_back('{3'd4, 32'h8000_0000, 32'd2,         5'd11, 32'hC000_0000, 33});
        vecs.push_back('{3'd5, 32'd5,          32'd0,         5'd12, 32'hFFFF_FFFF, 1});
        vecs.push_back('{3'd6, 32'd5,          32'd0,         5'd13, 32'd5,         1});
        vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1});
        vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0,         1});

        rst_in = 1'b0;
        rdy_in = 1'b1;
        flush_in = 1'b0;
        opValid_in = 1'b0;
        accept_in = 1'b0;
        op_in = '0;
        rs1Data_in = '0;
        rs2Data_in = '0;
        rdIdx_in = '0;
        repeat (2) @(negedge clk_in);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_rde", 32'(rdE_out), 32'd0);
        chk("rst_result", result_out, 32'd0);
        chk("rst_rdidx", 32'(rdIdx_out), 32'd0);
        chk("rst_stall", 32'(stallReq_out), 32'd0);
        rst_in = 1'b1;
        @(negedge clk_in);

        for (int i = 0; i < vecs.size(); i++) begin
            string n;
            n = $sformatf("v%0d", i);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b1, n);
            opValid_in = 1'b0;
            wait_done(lat, sok);
            chk({n, "_lat"}, 32'(lat), 32'(vecs[i].lat));
            chk({n, "_result"}, result_out, vecs[i].res);
            chk({n, "_rde"}, 32'(rdE_out), 32'(vecs[i].rd != 0));
            chk({n, "_rdidx"}, 32'(rdIdx_out), 32'(vecs[i].rd));
            chk({n, "_stall"}, 32'(sok), 32'd1);
            @(negedge clk_in);
            chk({n, "_idle"}, 32'(done_out), 32'd0);
        end

        issue(3'd0, 32'd3, 32'd5, 5'd4, 1'b0, "hold");
        wait_done(lat, sok);
        chk("hold_lat", 32'(lat), 32'd33);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            chk($sformatf("hold%0d_done", k), 32'(done_out), 32'd1);
            chk($sformatf("hold%0d_result", k), result_out, 32'd15);
            chk($sformatf("hold%0d_stall", k), 32'(stallReq_out), 32'd0);
        end
        accept_in = 1'b1;
        @(negedge clk_in);
        chk("hold_release_done", 32'(done_out), 32'd0);
        opValid_in = 1'b0;
        @(negedge clk_in);
        chk("hold_no_reissue", 32'(stallReq_out), 32'd0);

        issue(3'd5, 32'd100, 32'd7, 5'd6, 1'b1, "flush");
        opValid_in = 1'b0;
        repeat (9) @(negedge clk_in);
        flush_in = 1'b1;
        @(negedge clk_in);
        flush_in = 1'b0;
        chk("flush_stall", 32'(stallReq_out), 32'd0);
        chk("flush_done", 32'(done_out), 32'd0);
        sok = 1'b1;
        repeat (40) begin
            @(negedge clk_in);
            sok &= !done_out;
        end
        chk("flush_never_done", 32'(sok), 32'd1);

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 1'b1, "freeze");
        opValid_in = 1'b0;
        repeat (5) @(negedge clk_in);
        rdy_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rdy_in = 1'b1;
        lat = 9;
        while (!done_out && lat < 100) begin
            @(negedge clk_in);
            lat++;
        end
        chk("freeze_lat", 32'(lat), 32'd36);
        chk("freeze_result", result_out, 32'hFFFF_FFEB);
        @(negedge clk_in);

        issue(3'd4, 32'd1000, 32'd3, 5'd17, 1'b1, "rst");
        opValid_in = 1'b0;
        repeat (10) @(negedge clk_in);
        chk("rst_mid_rdidx_pre", 32'(rdIdx_out), 32'd17);
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        chk("rst_mid_done", 32'(done_out), 32'd0);
        chk("rst_mid_rde", 32'(rdE_out), 32'd0);
        chk("rst_mid_result", result_out, 32'd0);
        chk("rst_mid_rdidx", 32'(rdIdx_out), 32'd0);
        chk("rst_mid_stall", 32'(stallReq_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
